// File: rtl/gray_sweep_decoder.sv
// rtl/gray_sweep_decoder.sv - registered Gray-to-binary decoder with sweep sequence checker
//
// Purpose: decodes a 4-bit Gray word into binary through a one-deep
// valid/ready output register, and optionally checks that accepted words
// form an ascending 0..15 sweep.
//
// Ports:
//   clk                    single clock, rising edge
//   rst_n                  synchronous active-low reset
//   restart                synchronous pulse, re-arms the sweep checker
//   in_valid / in_ready    upstream handshake
//   y3..y0                 Gray-coded input word (y3 MSB)
//   out_valid / out_ready  downstream handshake
//   x3..x0                 decoded binary word (x3 MSB)
//   seq_err                one-cycle pulse alongside a word that broke the sequence
//   err_count              saturating count of sequence errors
//   sweep_done             level, a full sweep ending at 15 has completed
//
// Parameter CHECK_EN: 1 enables the checker; 0 leaves a pure registered decoder.

module gray_sweep_decoder #(
  parameter int CHECK_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       y3,
  input  logic       y2,
  input  logic       y1,
  input  logic       y0,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       x3,
  output logic       x2,
  output logic       x1,
  output logic       x0,
  output logic       seq_err,
  output logic [3:0] err_count,
  output logic       sweep_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit CHECK_ON = (CHECK_EN != 0);

  state_t     state;
  state_t     state_next;
  logic [3:0] exp;
  logic [3:0] exp_next;
  logic [3:0] dec;
  logic [3:0] x_reg;
  logic       accept;
  logic       err_hit;
  logic       gate;

  // Each binary bit is the XOR of the Gray bit with the binary bit above it.
  always_comb begin
    dec[3] = y3;
    dec[2] = dec[3] ^ y2;
    dec[1] = dec[2] ^ y1;
    dec[0] = dec[1] ^ y0;
  end

  // With the checker disabled, DONE and restart can never block the input.
  assign gate     = CHECK_ON ? ((state != DONE) && !restart) : 1'b1;
  assign in_ready = rst_n && (!out_valid || out_ready) && gate;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state;
    exp_next   = exp;
    err_hit    = 1'b0;
    if (CHECK_ON) begin
      if (restart) begin
        state_next = IDLE;
        exp_next   = 4'd0;
      end else if (accept) begin
        // The checker always resynchronises to the word just seen, so a
        // single skip produces exactly one error.
        exp_next = dec + 4'd1;
        case (state)
          IDLE: begin
            state_next = RUN;
            err_hit    = (dec != 4'd0);
          end
          RUN: begin
            err_hit = (dec != exp);
            if (dec == 4'd15) begin
              state_next = DONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      exp       <= 4'd0;
      seq_err   <= 1'b0;
      err_count <= 4'd0;
      out_valid <= 1'b0;
      x_reg     <= 4'd0;
    end else begin
      state   <= state_next;
      exp     <= exp_next;
      // Registered alongside the output word so the pulse lines up with it.
      seq_err <= err_hit;
      if (restart && CHECK_ON) begin
        err_count <= 4'd0;
      end else if (err_hit && (err_count != 4'd15)) begin
        err_count <= err_count + 4'd1;
      end
      if (accept) begin
        out_valid <= 1'b1;
        x_reg     <= dec;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign sweep_done = (state == DONE);
  assign {x3, x2, x1, x0} = x_reg;

endmodule

// File: tb/tb_gray_sweep_decoder.sv
// tb/tb_gray_sweep_decoder.sv - directed self-checking bench for gray_sweep_decoder

module tb_gray_sweep_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic       in_valid;
  logic       in_ready;
  logic       y3, y2, y1, y0;
  logic       out_valid;
  logic       out_ready;
  logic       x3, x2, x1, x0;
  logic       seq_err;
  logic [3:0] err_count;
  logic       sweep_done;

  int compared = 0;
  int mismatched = 0;

  gray_sweep_decoder #(.CHECK_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .out_valid(out_valid), .out_ready(out_ready),
    .x3(x3), .x2(x2), .x1(x1), .x0(x0),
    .seq_err(seq_err), .err_count(err_count), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] g);
    in_valid = v;
    {y3, y2, y1, y0} = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] xo();
    return {x3, x2, x1, x0};
  endfunction

  initial begin
    rst_n = 1'b0; restart = 1'b0; out_ready = 1'b1;
    drive(1'b1, 4'b0101);
    #2;
    check("in_ready_in_reset", {7'd0, in_ready}, 8'd0);
    tick();
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_x", {4'd0, xo()}, 8'd0);
    check("rst_seq_err", {7'd0, seq_err}, 8'd0);
    check("rst_err_count", {4'd0, err_count}, 8'd0);
    check("rst_sweep_done", {7'd0, sweep_done}, 8'd0);

    // Clean full sweep, one word per cycle.
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, gray(n));
      #1;
      check("sweep_in_ready", {7'd0, in_ready}, 8'd1);
      tick();
      check("sweep_out_valid", {7'd0, out_valid}, 8'd1);
      check("sweep_x", {4'd0, xo()}, n[7:0]);
      check("sweep_seq_err", {7'd0, seq_err}, 8'd0);
    end
    drive(1'b0, 4'd0);
    #1;
    check("sweep_err_count", {4'd0, err_count}, 8'd0);
    check("sweep_done", {7'd0, sweep_done}, 8'd1);
    check("done_in_ready", {7'd0, in_ready}, 8'd0);
    tick();
    check("done_drained", {7'd0, out_valid}, 8'd0);

    // Restart in DONE together with a valid word: the word is dropped.
    restart = 1'b1;
    drive(1'b1, gray(0));
    #1;
    check("restart_in_ready", {7'd0, in_ready}, 8'd0);
    tick();
    restart = 1'b0;
    drive(1'b0, 4'd0);
    check("restart_sweep_done", {7'd0, sweep_done}, 8'd0);
    check("restart_err_count", {4'd0, err_count}, 8'd0);
    check("restart_dropped", {7'd0, out_valid}, 8'd0);

    // Skipped value: 0,1,2,4,5 -> one error coincident with decoded 4.
    drive(1'b1, gray(0)); tick();
    check("skip_x0", {4'd0, xo()}, 8'd0);
    drive(1'b1, gray(1)); tick();
    drive(1'b1, gray(2)); tick();
    check("skip_no_err_2", {7'd0, seq_err}, 8'd0);
    drive(1'b1, gray(4)); tick();
    check("skip_x4", {4'd0, xo()}, 8'd4);
    check("skip_err_pulse", {7'd0, seq_err}, 8'd1);
    check("skip_err_count", {4'd0, err_count}, 8'd1);
    drive(1'b1, gray(5)); tick();
    check("skip_x5", {4'd0, xo()}, 8'd5);
    check("skip_no_err_5", {7'd0, seq_err}, 8'd0);
    check("skip_err_count_hold", {4'd0, err_count}, 8'd1);
    drive(1'b0, 4'd0);
    restart = 1'b1; tick(); restart = 1'b0;

    // Backpressure: first word held for three stalled cycles.
    out_ready = 1'b0;
    drive(1'b1, gray(0)); tick();
    check("bp_first_valid", {7'd0, out_valid}, 8'd1);
    check("bp_first_x", {4'd0, xo()}, 8'd0);
    drive(1'b1, gray(1));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready_low", {7'd0, in_ready}, 8'd0);
      tick();
      check("bp_hold_x", {4'd0, xo()}, 8'd0);
      check("bp_hold_valid", {7'd0, out_valid}, 8'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", {7'd0, in_ready}, 8'd1);
    tick();
    check("bp_x1", {4'd0, xo()}, 8'd1);
    drive(1'b1, gray(2)); tick();
    check("bp_x2", {4'd0, xo()}, 8'd2);
    check("bp_valid2", {7'd0, out_valid}, 8'd1);
    drive(1'b0, 4'd0); tick();
    check("bp_drained", {7'd0, out_valid}, 8'd0);
    check("bp_err_count", {4'd0, err_count}, 8'd0);
    restart = 1'b1; tick(); restart = 1'b0;

    // Saturation: Gray 0101 decodes to 6 and is wrong every time.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b0101); tick();
      check("sat_x", {4'd0, xo()}, 8'd6);
      check("sat_err_pulse", {7'd0, seq_err}, 8'd1);
      check("sat_err_count", {4'd0, err_count}, (i < 15) ? 8'(i + 1) : 8'd15);
    end
    drive(1'b0, 4'd0);
    restart = 1'b1; tick(); restart = 1'b0;

    // Reset mid-sweep with a word held and an error already counted.
    out_ready = 1'b0;
    drive(1'b1, gray(0)); tick();
    out_ready = 1'b1;
    drive(1'b1, gray(1)); tick();
    drive(1'b1, gray(3)); tick();
    check("pre_rst_err_count", {4'd0, err_count}, 8'd1);
    out_ready = 1'b0;
    drive(1'b1, gray(4));
    rst_n = 1'b0; restart = 1'b1;
    tick();
    check("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("mid_rst_x", {4'd0, xo()}, 8'd0);
    check("mid_rst_err_count", {4'd0, err_count}, 8'd0);
    check("mid_rst_seq_err", {7'd0, seq_err}, 8'd0);
    check("mid_rst_in_ready", {7'd0, in_ready}, 8'd0);
    rst_n = 1'b1; restart = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, gray(n)); tick();
      check("post_rst_x", {4'd0, xo()}, n[7:0]);
      check("post_rst_seq_err", {7'd0, seq_err}, 8'd0);
    end
    drive(1'b0, 4'd0);
    check("post_rst_err_count", {4'd0, err_count}, 8'd0);
    check("post_rst_sweep_done", {7'd0, sweep_done}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
